// File: rtl/otter_pkg.sv
// Shared OTTER definitions: NOP encoding and the fetch-buffer entry layout.
package otter_pkg;

   localparam logic [31:0] OTTER_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Synchronous FIFO of fetch entries; reset and flush clear pointers only, storage is never reset.
module otter_fetch_fifo
   import otter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             din,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t   mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= din;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: PC, imem port-1 reads, {IR,PC} buffer, valid/ready to decode.
// Optional same-cycle response bypass to decode: define OTTER_FETCH_BYPASS_EN.
module otter_fetch_unit
   import otter_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic        IMEM_RDEN,
   output logic [13:0] IMEM_ADDR,
   input  logic [31:0] IMEM_DOUT,
   input  logic        REDIRECT_VALID,
   input  logic [31:0] REDIRECT_PC,
   output logic        DE_VALID,
   input  logic        DE_READY,
   output logic [31:0] DE_IR,
   output logic [31:0] DE_PC
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   issue_addr;
   logic          issue, resp, pop, push, fifo_pop, byp;
   logic [CW:0]   occ;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head, resp_entry;
   logic          unused_redirect_lsb;

   assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

   // A redirect kills the returning word; the read it belonged to is on the wrong path.
   assign resp       = inflight_q & ~REDIRECT_VALID & ~RESET;
   assign resp_entry = '{ir: IMEM_DOUT, pc: inflight_pc_q};

`ifdef OTTER_FETCH_BYPASS_EN
   assign byp = resp & (fifo_count == '0);
`else
   assign byp = 1'b0;
`endif

   assign DE_VALID = ~RESET & ~REDIRECT_VALID & ((fifo_count != '0) | byp);
   assign pop      = DE_VALID & DE_READY;
   assign push     = resp & ~(byp & DE_READY);
   assign fifo_pop = pop & ~byp;

   always_comb begin
      DE_IR = OTTER_NOP;
      DE_PC = '0;
      if (DE_VALID) begin
         DE_IR = byp ? resp_entry.ir : fifo_head.ir;
         DE_PC = byp ? resp_entry.pc : fifo_head.pc;
      end
   end

   // Slots committed after this cycle: buffered + in flight - leaving now.
   assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

   assign issue      = ~RESET & (REDIRECT_VALID | (occ < (CW+1)'(DEPTH)));
   assign issue_addr = REDIRECT_VALID ? {REDIRECT_PC[31:2], 2'b00} : pc_q;
   assign IMEM_RDEN  = issue;
   assign IMEM_ADDR  = issue_addr[15:2];

   always_comb begin
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      if (issue) begin
         pc_d          = issue_addr + 32'd4;
         inflight_pc_d = issue_addr;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   otter_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .reset (RESET),
      .push  (push),
      .pop   (fifo_pop),
      .flush (REDIRECT_VALID),
      .din   (resp_entry),
      .head  (fifo_head),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: directed scenarios then random ready/redirect/reset against a stream model.
module tb_otter_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef OTTER_FETCH_BYPASS_EN
   localparam int          LAT      = 1;
`else
   localparam int          LAT      = 2;
`endif

   logic        CLK = 1'b0;
   logic        RESET, IMEM_RDEN, REDIRECT_VALID, DE_VALID, DE_READY;
   logic [13:0] IMEM_ADDR;
   logic [31:0] IMEM_DOUT, REDIRECT_PC, DE_IR, DE_PC;

   int total = 0;
   int bad   = 0;

   // stream model: next PC decode must see, next PC fetch must issue, words fetched but not yet delivered
   logic [31:0] exp_pc, issue_pc;
   int          outst;
   int          since;
   bit          in_reset;

   otter_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .IMEM_RDEN      (IMEM_RDEN),
      .IMEM_ADDR      (IMEM_ADDR),
      .IMEM_DOUT      (IMEM_DOUT),
      .REDIRECT_VALID (REDIRECT_VALID),
      .REDIRECT_PC    (REDIRECT_PC),
      .DE_VALID       (DE_VALID),
      .DE_READY       (DE_READY),
      .DE_IR          (DE_IR),
      .DE_PC          (DE_PC)
   );

   always #5 CLK = ~CLK;

   // memory returns the byte address of the word; garbage when not read
   always @(posedge CLK) begin
      if (IMEM_RDEN) IMEM_DOUT <= {16'h0000, IMEM_ADDR, 2'b00};
      else           IMEM_DOUT <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic observe();
      if (RESET) begin
         chk("rst_rden",  {31'b0, IMEM_RDEN}, 32'd0);
         chk("rst_valid", {31'b0, DE_VALID},  32'd0);
         chk("rst_ir",    DE_IR, NOP);
         chk("rst_pc",    DE_PC, 32'd0);
         in_reset = 1'b1;
         return;
      end
      if (in_reset || REDIRECT_VALID) begin
         exp_pc   = REDIRECT_VALID ? {REDIRECT_PC[31:2], 2'b00} : RESET_PC;
         issue_pc = exp_pc + 32'd4;
         since    = 0;
         outst    = 0;
         in_reset = 1'b0;
         chk("restart_valid", {31'b0, DE_VALID},  32'd0);
         chk("restart_rden",  {31'b0, IMEM_RDEN}, 32'd1);
         chk("restart_addr",  {18'b0, IMEM_ADDR}, {18'b0, exp_pc[15:2]});
      end else begin
         since++;
         if (since < LAT)       chk("bubble",    {31'b0, DE_VALID}, 32'd0);
         else if (since == LAT) chk("lat_valid", {31'b0, DE_VALID}, 32'd1);
         if (DE_VALID && DE_READY) begin
            chk("de_pc", DE_PC, exp_pc);
            chk("de_ir", DE_IR, {16'h0000, exp_pc[15:0]});
            exp_pc += 32'd4;
            outst--;
         end
         if (IMEM_RDEN) begin
            chk("issue_addr", {18'b0, IMEM_ADDR}, {18'b0, issue_pc[15:2]});
            issue_pc += 32'd4;
         end
      end
      if (!DE_VALID) begin
         chk("idle_ir", DE_IR, NOP);
         chk("idle_pc", DE_PC, 32'd0);
      end
      if (IMEM_RDEN) outst++;
      chk("bound", {31'b0, (outst <= DEPTH)}, 32'd1);
   endtask

   task automatic cycle();
      #1;
      observe();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      in_reset       = 1'b1;
      exp_pc         = RESET_PC;
      issue_pc       = RESET_PC;
      outst          = 0;
      since          = 0;
      RESET          = 1'b1;
      DE_READY       = 1'b1;
      REDIRECT_VALID = 1'b0;
      REDIRECT_PC    = '0;
      repeat (3) cycle();

      // free run
      RESET = 1'b0;
      repeat (10) cycle();

      // backpressure: buffer fills to DEPTH, then fetch stops
      DE_READY = 1'b0;
      repeat (5) cycle();
      #1;
      chk("bp_rden_off", {31'b0, IMEM_RDEN}, 32'd0);
      chk("bp_full",     outst, DEPTH);
      cycle();
      DE_READY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("bp_release_valid", {31'b0, DE_VALID}, 32'd1);
         cycle();
      end

      // redirect while full, with decode ready in the same cycle
      DE_READY = 1'b0;
      repeat (4) cycle();
      REDIRECT_VALID = 1'b1;
      REDIRECT_PC    = 32'h0000_0100;
      DE_READY       = 1'b1;
      #1;
      chk("redir_addr", {18'b0, IMEM_ADDR}, 32'h0000_0040);
      cycle();
      REDIRECT_VALID = 1'b0;
      repeat (LAT + 4) cycle();

      // wrap, with and without low address bits set
      for (int k = 0; k < 2; k++) begin
         REDIRECT_VALID = 1'b1;
         REDIRECT_PC    = (k == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
         #1;
         chk("wrap_addr_hi", {18'b0, IMEM_ADDR}, 32'h0000_3FFF);
         cycle();
         REDIRECT_VALID = 1'b0;
         #1;
         chk("wrap_addr_lo", {18'b0, IMEM_ADDR}, 32'h0000_0000);
         for (int j = 1; j < LAT; j++) cycle();
         #1;
         chk("wrap_pc_hi", DE_PC, 32'hFFFF_FFFC);
         cycle();
         #1;
         chk("wrap_pc_lo", DE_PC, 32'h0000_0000);
         repeat (3) cycle();
      end

      // reset with a full buffer
      DE_READY = 1'b0;
      repeat (4) cycle();
      RESET = 1'b1;
      cycle();
      RESET    = 1'b0;
      DE_READY = 1'b1;
      #1;
      chk("rst_first_addr", {18'b0, IMEM_ADDR}, {18'b0, RESET_PC[15:2]});
      repeat (LAT + 4) cycle();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         DE_READY       = ($urandom_range(0, 3) != 0);
         REDIRECT_VALID = ($urandom_range(0, 19) == 0);
         REDIRECT_PC    = $urandom;
         RESET          = ($urandom_range(0, 99) == 0);
         cycle();
      end
      RESET          = 1'b0;
      REDIRECT_VALID = 1'b0;
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
